ex_alu_mdu: RTL and testbench
=============================

# ex_alu_mdu

Parametrised execute-stage arithmetic unit for the RV32 pipeline. It combines the integer ALU ops with an iterative RV32M multiply/divide datapath behind a valid/ready handshake, so the EX stage can stall on multi-cycle ops. Single-cycle ops keep one-per-cycle throughput. The unit sits between the EX_STATE pipeline register and the MEM_STATE register; it returns a registered result plus an illegal-op flag.

## Interface
- XLEN, 32, datapath width; must be a power of two, ≥ 8
- MUL_EN, 1, 1 enables MUL/MULH/MULHSU/MULHU; 0 makes them illegal
- DIV_EN, 1, 1 enables DIV/DIVU/REM/REMU; 0 makes them illegal

- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_flush  in  1  synchronous abort of any in-flight op
- i_valid  in  1  request valid
- o_ready  out  1  unit accepts a request this cycle
- i_op  in  5  opcode: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; all other codes are illegal
- i_a  in  XLEN  operand A (rs1)
- i_b  in  XLEN  operand B (rs2 or sign-extended immediate)
- o_valid  out  1  result valid; held until consumed
- i_ready  in  1  consumer accepts the result
- o_result  out  XLEN  result
- o_illegal  out  1  result came from an illegal or disabled op; o_result = 0

## Operation
- States: IDLE, MUL, DIV, DONE. A request is accepted when i_valid && o_ready at a clock edge.
- o_ready = (state==IDLE) || (state==DONE && i_ready). This is a combinational path from i_ready.
- Single-cycle ops (0–9, illegal, divide special cases): the result is computed in the accept cycle and registered. The next state is DONE.
- Shift amount = i_b[log2(XLEN)-1:0]. Upper bits are ignored.
- SRA is a true arithmetic shift: every vacated bit equals i_a[XLEN-1].
- SLT/SLTU return 0 or 1, zero-extended.
- Multiply (accept → MUL):
  - Latch the operand magnitudes and the result sign according to the op's signedness: MULHSU treats A as signed and B as unsigned.
  - Run XLEN shift-add iterations into a 2·XLEN product register, with the counter counting 0..XLEN-1.
  - On the last iteration, negate if the sign is set, select the low half (MUL) or high half (others), register the result, and go to DONE.
- Divide (accept → DIV):
  - Restoring divide on magnitudes, XLEN iterations.
  - On the last iteration, apply signs: the quotient sign is sA^sB; the remainder takes the dividend's sign. Select quotient or remainder, then go to DONE.
- Divide special cases are short-circuited, finish in 1 cycle, and never enter DIV:
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (A = -2^(XLEN-1), B = -1): quotient = A; remainder = 0.
- DONE: o_valid=1, with o_result and o_illegal stable.
  - On i_ready with no new accept, go to IDLE.
  - On i_ready with a simultaneous accept, load the new op (behaves as if accepted from IDLE).
- Flush: i_flush=1 at an edge forces IDLE, o_valid=0 and counter=0. A flush beats a simultaneous accept, and the request in that cycle is dropped.
- Reset: same effect as flush, and in addition o_result=0 and o_illegal=0. Reset overrides flush.

## Timing
- Reset values: state IDLE, o_valid 0, o_result 0, o_illegal 0, o_ready 1, iteration counter 0.
- Latency is measured from the accept edge E to the first edge where o_valid is sampled high:
  - Single-cycle and special-case ops: o_valid is high after E+1.
  - MUL family and normal divides: o_valid is high after E+XLEN+1 (33 cycles at XLEN=32).
- Throughput:
  - Single-cycle ops: one per cycle while i_ready stays high.
  - Multi-cycle ops: one per XLEN+1 cycles, plus any consumer backpressure.
- Backpressure: while o_valid && !i_ready, all outputs hold and o_ready=0.
- Inputs i_a, i_b and i_op are sampled only at the accept edge; they may change during MUL/DIV.
- o_ready is 0 throughout MUL and DIV.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → 0x80000000, o_valid one cycle later. SRA with a=0x80000000, b=0x24 → 0xF8000000 (shamt 4). Opcode 25 → o_illegal=1, result 0.
- a=0xFFFFFFFF, b=0x00000002:
  - MUL → 0xFFFFFFFE
  - MULH → 0xFFFFFFFF
  - MULHU → 0x00000001
  - MULHSU → 0xFFFFFFFF
  - Each asserts o_valid exactly 33 cycles after accept.
- Signed divide:
  - DIV -7 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF (33-cycle latency).
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0 (1-cycle latency).
- Unsigned divide by zero: DIVU 7/0 → 0xFFFFFFFF and REMU 7/0 → 7, both with 1-cycle latency. With DIV_EN=0, DIVU 7/3 → o_illegal=1.
- Handshake:
  - Five back-to-back ADDs with i_ready=1 → five consecutive o_valid cycles.
  - Then hold i_ready=0 for 4 cycles → o_result stable, o_ready=0.
  - Then release → the queued request is accepted on the same edge the result is consumed.
- Abort:
  - i_flush in the 10th cycle of a DIV → no o_valid, o_ready=1 on the next cycle.
  - i_reset mid-MUL → all outputs reach reset values after one edge, and a subsequent MUL 3×5 → 15.

Source files
------------

// File: rtl/ex_alu_mdu.sv
// Execute-stage ALU with an iterative RV32M multiply/divide unit behind a valid/ready handshake.
// Single-cycle ops and divide special cases finish on the accept edge; MUL/DIV iterate XLEN cycles.
module ex_alu_mdu #(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1,
  parameter bit DIV_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_illegal
);

  localparam int SW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
  localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU = 5'd15;
  localparam logic [4:0] OP_REM = 5'd16, OP_REMU = 5'd17;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic              neg_q, neg_d;
  logic              sel_q, sel_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              illegal_q, illegal_d;

  logic              accept;
  logic              isAlu, isMulOp, isDivOp, illegalOp;
  logic              isRem, divSigned, sA, sB;
  logic              divByZero, divOvf;
  logic [XLEN-1:0]   magA, magB, aluRes;
  logic [SW-1:0]     shamt;
  logic [XLEN:0]     mulSum, divShift, divDiff;
  logic [2*XLEN-1:0] mulNext, mulFinal, divNext;
  logic [XLEN-1:0]   divPick, divFinal;
  logic              divFits, lastIter;

  assign o_ready   = (state_q == IDLE) || ((state_q == DONE) && i_ready);
  assign o_valid   = (state_q == DONE);
  assign o_result  = result_q;
  assign o_illegal = illegal_q;
  assign accept    = i_valid && o_ready;

  assign isAlu     = (i_op <= OP_AND);
  assign isMulOp   = (i_op >= OP_MUL) && (i_op <= OP_MULHU);
  assign isDivOp   = (i_op >= OP_DIV) && (i_op <= OP_REMU);
  assign illegalOp = !(isAlu || (isMulOp && MUL_EN) || (isDivOp && DIV_EN));
  assign isRem     = (i_op == OP_REM) || (i_op == OP_REMU);
  assign divSigned = (i_op == OP_DIV) || (i_op == OP_REM);

  // Operand signs follow each op's signedness; MULHSU treats B as unsigned.
  assign sA = i_a[XLEN-1] && (isMulOp ? (i_op != OP_MULHU) : divSigned);
  assign sB = i_b[XLEN-1] && (isMulOp ? ((i_op == OP_MUL) || (i_op == OP_MULH)) : divSigned);
  assign magA = sA ? (~i_a + 1'b1) : i_a;
  assign magB = sB ? (~i_b + 1'b1) : i_b;

  assign divByZero = (i_b == '0);
  assign divOvf    = divSigned && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == '1);

  assign shamt = i_b[SW-1:0];

  always_comb begin
    aluRes = '0;
    case (i_op)
      OP_ADD:  aluRes = i_a + i_b;
      OP_SUB:  aluRes = i_a - i_b;
      OP_SLL:  aluRes = i_a << shamt;
      OP_SLT:  aluRes = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      OP_SLTU: aluRes = {{(XLEN-1){1'b0}}, i_a < i_b};
      OP_XOR:  aluRes = i_a ^ i_b;
      OP_SRL:  aluRes = i_a >> shamt;
      OP_SRA:  aluRes = $unsigned($signed(i_a) >>> shamt);
      OP_OR:   aluRes = i_a | i_b;
      OP_AND:  aluRes = i_a & i_b;
      default: aluRes = '0;
    endcase
  end

  // Shift-add: multiplier sits in the low half and shifts out as the partial product grows.
  assign mulSum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? opnd_q : {XLEN{1'b0}})};
  assign mulNext  = {mulSum, prod_q[XLEN-1:1]};
  assign mulFinal = neg_q ? (~mulNext + 1'b1) : mulNext;

  // Restoring divide: upper half is the partial remainder, lower half shifts dividend into quotient.
  assign divShift = prod_q[2*XLEN-1:XLEN-1];
  assign divDiff  = divShift - {1'b0, opnd_q};
  assign divFits  = !divDiff[XLEN];
  assign divNext  = {(divFits ? divDiff[XLEN-1:0] : divShift[XLEN-1:0]), prod_q[XLEN-2:0], divFits};
  assign divPick  = sel_q ? divNext[2*XLEN-1:XLEN] : divNext[XLEN-1:0];
  assign divFinal = neg_q ? (~divPick + 1'b1) : divPick;

  assign lastIter = (cnt_q == SW'(XLEN-1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    prod_d    = prod_q;
    neg_d     = neg_q;
    sel_d     = sel_q;
    result_d  = result_q;
    illegal_d = illegal_q;

    case (state_q)
      MUL: begin
        prod_d = mulNext;
        cnt_d  = cnt_q + SW'(1);
        if (lastIter) begin
          result_d  = sel_q ? mulFinal[2*XLEN-1:XLEN] : mulFinal[XLEN-1:0];
          illegal_d = 1'b0;
          cnt_d     = '0;
          state_d   = DONE;
        end
      end
      DIV: begin
        prod_d = divNext;
        cnt_d  = cnt_q + SW'(1);
        if (lastIter) begin
          result_d  = divFinal;
          illegal_d = 1'b0;
          cnt_d     = '0;
          state_d   = DONE;
        end
      end
      DONE:    if (i_ready) state_d = IDLE;
      default: ;
    endcase

    if (accept) begin
      illegal_d = 1'b0;
      cnt_d     = '0;
      state_d   = DONE;
      if (illegalOp) begin
        result_d  = '0;
        illegal_d = 1'b1;
      end else if (isMulOp) begin
        opnd_d  = magA;
        prod_d  = {{XLEN{1'b0}}, magB};
        neg_d   = sA ^ sB;
        sel_d   = (i_op != OP_MUL);
        state_d = MUL;
      end else if (isDivOp) begin
        if (divByZero) begin
          result_d = isRem ? i_a : '1;
        end else if (divOvf) begin
          result_d = isRem ? '0 : i_a;
        end else begin
          opnd_d  = magB;
          prod_d  = {{XLEN{1'b0}}, magA};
          neg_d   = isRem ? sA : (sA ^ sB);
          sel_d   = isRem;
          state_d = DIV;
        end
      end else begin
        result_d = aluRes;
      end
    end

    if (i_flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      opnd_q    <= '0;
      prod_q    <= '0;
      neg_q     <= 1'b0;
      sel_q     <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      prod_q    <= prod_d;
      neg_q     <= neg_d;
      sel_q     <= sel_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_ex_alu_mdu.sv
// Directed bench for ex_alu_mdu: ALU ops, multiply/divide values and latency, handshake and abort.
module tb_ex_alu_mdu;

  logic        clk = 1'b0;
  logic        resetI = 1'b1, flushI = 1'b0, validI = 1'b0, readyI = 1'b1;
  logic [4:0]  opI = '0;
  logic [31:0] aI = '0, bI = '0;
  logic        readyO, validO, illegalO;
  logic [31:0] resultO;

  logic        valid2I = 1'b0;
  logic [4:0]  op2I = '0;
  logic        ready2O, valid2O, illegal2O;
  logic [31:0] result2O;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  ex_alu_mdu #(.XLEN(32), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut (
    .i_clk(clk), .i_reset(resetI), .i_flush(flushI), .i_valid(validI), .o_ready(readyO),
    .i_op(opI), .i_a(aI), .i_b(bI), .o_valid(validO), .i_ready(readyI),
    .o_result(resultO), .o_illegal(illegalO)
  );

  ex_alu_mdu #(.XLEN(32), .MUL_EN(1'b1), .DIV_EN(1'b0)) dutNoDiv (
    .i_clk(clk), .i_reset(resetI), .i_flush(flushI), .i_valid(valid2I), .o_ready(ready2O),
    .i_op(op2I), .i_a(aI), .i_b(bI), .o_valid(valid2O), .i_ready(readyI),
    .o_result(result2O), .o_illegal(illegal2O)
  );

  // Issues one request (called #1 after an edge) and waits for its result.
  task automatic runOp(input logic [4:0] opc, input logic [31:0] aa, input logic [31:0] bb,
                       output logic [31:0] res, output logic ill, output int lat);
    opI = opc; aI = aa; bI = bb; validI = 1'b1;
    @(posedge clk); #1;
    validI = 1'b0;
    lat = 1;
    while (!validO && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = resultO;
    ill = illegalO;
  endtask

  task automatic test_reset;
    resetI = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetI = 1'b0;
    checkCount++; if (validO !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", validO); else passCount++;
    checkCount++; if (resultO !== 32'h0) $display("[TB] FAIL reset_result got %h want 0", resultO); else passCount++;
    checkCount++; if (illegalO !== 1'b0) $display("[TB] FAIL reset_illegal got %b want 0", illegalO); else passCount++;
    checkCount++; if (readyO !== 1'b1) $display("[TB] FAIL reset_ready got %b want 1", readyO); else passCount++;
  endtask

  task automatic test_alu;
    logic [4:0]  ops [11] = '{5'd0, 5'd7, 5'd1, 5'd3, 5'd4, 5'd2, 5'd6, 5'd5, 5'd8, 5'd9, 5'd25};
    logic [31:0] as [11]  = '{32'h7FFFFFFF, 32'h80000000, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,
                              32'h80000000, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFF0000, 32'h12345678};
    logic [31:0] bs [11]  = '{32'd1, 32'h24, 32'd7, 32'd1, 32'd1, 32'h21,
                              32'd4, 32'hFF00FF00, 32'h000000F0, 32'h12345678, 32'h9};
    logic [31:0] exps [11] = '{32'h80000000, 32'hF8000000, 32'hFFFFFFFE, 32'd1, 32'd0, 32'd2,
                               32'h08000000, 32'h0FF00FF0, 32'h0F0F00F0, 32'h12340000, 32'd0};
    logic [31:0] res;
    logic        ill;
    int          lat;
    for (int i = 0; i < 11; i++) begin
      runOp(ops[i], as[i], bs[i], res, ill, lat);
      checkCount++; if (res !== exps[i]) $display("[TB] FAIL alu_result[%0d] op %0d got %h want %h", i, ops[i], res, exps[i]); else passCount++;
      checkCount++; if (ill !== (i == 10)) $display("[TB] FAIL alu_illegal[%0d] got %b want %b", i, ill, (i == 10)); else passCount++;
      checkCount++; if (lat !== 1) $display("[TB] FAIL alu_latency[%0d] got %0d want 1", i, lat); else passCount++;
    end
  endtask

  task automatic test_mul;
    logic [4:0]  ops [7] = '{5'd10, 5'd11, 5'd13, 5'd12, 5'd11, 5'd12, 5'd10};
    logic [31:0] as [7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'h80000000, 32'h80000000, 32'h12345678};
    logic [31:0] bs [7]  = '{32'd2, 32'd2, 32'd2, 32'd2, 32'h80000000, 32'hFFFFFFFF, 32'h10};
    logic [31:0] exps [7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF,
                              32'h40000000, 32'h80000000, 32'h23456780};
    logic [31:0] res;
    logic        ill;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      runOp(ops[i], as[i], bs[i], res, ill, lat);
      checkCount++; if (res !== exps[i]) $display("[TB] FAIL mul_result[%0d] op %0d got %h want %h", i, ops[i], res, exps[i]); else passCount++;
      checkCount++; if (lat !== 33) $display("[TB] FAIL mul_latency[%0d] got %0d want 33", i, lat); else passCount++;
    end
  endtask

  task automatic test_div;
    logic [4:0]  ops [12] = '{5'd14, 5'd16, 5'd14, 5'd16, 5'd15, 5'd17, 5'd15, 5'd17,
                              5'd16, 5'd14, 5'd14, 5'd16};
    logic [31:0] as [12]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000, 32'd7, 32'd7,
                              32'd100, 32'd100, 32'd7, 32'd7, 32'hFFFFFFFB, 32'hFFFFFFFB};
    logic [31:0] bs [12]  = '{32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,
                              32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd0, 32'd0};
    logic [31:0] exps [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd7,
                               32'd14, 32'd2, 32'd1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFB};
    int          lats [12] = '{33, 33, 1, 1, 1, 1, 33, 33, 33, 33, 1, 1};
    logic [31:0] res;
    logic        ill;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      runOp(ops[i], as[i], bs[i], res, ill, lat);
      checkCount++; if (res !== exps[i]) $display("[TB] FAIL div_result[%0d] op %0d got %h want %h", i, ops[i], res, exps[i]); else passCount++;
      checkCount++; if (lat !== lats[i]) $display("[TB] FAIL div_latency[%0d] got %0d want %0d", i, lat, lats[i]); else passCount++;
    end
  endtask

  task automatic test_div_disabled;
    op2I = 5'd15; aI = 32'd7; bI = 32'd3; valid2I = 1'b1;
    @(posedge clk); #1;
    valid2I = 1'b0;
    checkCount++; if (valid2O !== 1'b1) $display("[TB] FAIL nodiv_valid got %b want 1", valid2O); else passCount++;
    checkCount++; if (illegal2O !== 1'b1) $display("[TB] FAIL nodiv_illegal got %b want 1", illegal2O); else passCount++;
    checkCount++; if (result2O !== 32'd0) $display("[TB] FAIL nodiv_result got %h want 0", result2O); else passCount++;
    op2I = 5'd0; valid2I = 1'b1;
    @(posedge clk); #1;
    valid2I = 1'b0;
    checkCount++; if (result2O !== 32'd10 || illegal2O !== 1'b0) $display("[TB] FAIL nodiv_add got %h/%b want 0000000a/0", result2O, illegal2O); else passCount++;
  endtask

  task automatic test_back_to_back;
    readyI = 1'b1;
    opI = 5'd0; bI = 32'd1; validI = 1'b1;
    for (int k = 0; k < 5; k++) begin
      aI = 32'd10 + 32'(k);
      @(posedge clk); #1;
      checkCount++; if (validO !== 1'b1 || resultO !== 32'd11 + 32'(k)) $display("[TB] FAIL b2b[%0d] got %b/%h want 1/%h", k, validO, resultO, 32'd11 + 32'(k)); else passCount++;
    end
    readyI = 1'b0; aI = 32'd100;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkCount++; if (validO !== 1'b1 || resultO !== 32'd15 || readyO !== 1'b0) $display("[TB] FAIL stall[%0d] got v%b r%b %h want v1 r0 0000000f", k, validO, readyO, resultO); else passCount++;
    end
    readyI = 1'b1;
    @(posedge clk); #1;
    validI = 1'b0;
    checkCount++; if (validO !== 1'b1 || resultO !== 32'd101) $display("[TB] FAIL release got %b/%h want 1/00000065", validO, resultO); else passCount++;
    @(posedge clk); #1;
    checkCount++; if (validO !== 1'b0) $display("[TB] FAIL drain_valid got %b want 0", validO); else passCount++;
  endtask

  task automatic test_flush;
    int seen = 0;
    opI = 5'd14; aI = 32'd100; bI = 32'd7; validI = 1'b1;
    @(posedge clk); #1;
    validI = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    flushI = 1'b1;
    @(posedge clk); #1;
    flushI = 1'b0;
    checkCount++; if (validO !== 1'b0 || readyO !== 1'b1) $display("[TB] FAIL flush_state got v%b r%b want v0 r1", validO, readyO); else passCount++;
    repeat (40) begin
      @(posedge clk); #1;
      if (validO) seen++;
    end
    checkCount++; if (seen !== 0) $display("[TB] FAIL flush_no_result got %0d valid cycles want 0", seen); else passCount++;
    opI = 5'd0; aI = 32'd1; bI = 32'd1; validI = 1'b1; flushI = 1'b1;
    @(posedge clk); #1;
    validI = 1'b0; flushI = 1'b0;
    checkCount++; if (validO !== 1'b0 || readyO !== 1'b1) $display("[TB] FAIL flush_beats_accept got v%b r%b want v0 r1", validO, readyO); else passCount++;
  endtask

  task automatic test_reset_mid_mul;
    logic [31:0] res;
    logic        ill;
    int          lat;
    runOp(5'd0, 32'd1, 32'd2, res, ill, lat);
    opI = 5'd10; aI = 32'd9; bI = 32'd9; validI = 1'b1;
    @(posedge clk); #1;
    validI = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    resetI = 1'b1;
    @(posedge clk); #1;
    resetI = 1'b0;
    checkCount++; if (validO !== 1'b0 || readyO !== 1'b1) $display("[TB] FAIL midreset_state got v%b r%b want v0 r1", validO, readyO); else passCount++;
    checkCount++; if (resultO !== 32'd0 || illegalO !== 1'b0) $display("[TB] FAIL midreset_outputs got %h/%b want 0/0", resultO, illegalO); else passCount++;
    runOp(5'd10, 32'd3, 32'd5, res, ill, lat);
    checkCount++; if (res !== 32'd15 || lat !== 33) $display("[TB] FAIL mul_after_reset got %h lat %0d want 0000000f lat 33", res, lat); else passCount++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_div_disabled();
    test_back_to_back();
    test_flush();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
